// File: rtl/counter_pkg.sv
// Shared types and constants for the multi-channel counter.
//   cnt_mode_e : wrap / saturate selector encoding
//   DIR_UP/DOWN: per-channel direction encoding
//   calc_ch_w  : channel-index width for a given channel count (minimum 1)
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width needed to index nch channels; a single channel still gets one bit.
    function automatic int unsigned calc_ch_w(input int unsigned nch);
        return (nch > 32'd1) ? 32'($clog2(nch)) : 32'd1;
    endfunction

endpackage : counter_pkg

// File: rtl/counter_chan.sv
// One counter channel: count register, terminal-count pulse, sticky overflow.
// Saturate support is compiled in only when COUNTER_SAT_EN is defined;
// otherwise the channel always wraps and mode is ignored.
// Ports:
//   clk, reset_n : clock, async active-low reset
//   clr          : synchronous clear of the count (highest priority)
//   load         : load strobe already decoded for this channel
//   load_val     : value to load
//   cnt_en, dir  : step enable and direction (0 up, 1 down)
//   limit        : terminal value, count range 0..limit
//   mode         : 0 wrap, 1 saturate
//   ovf_clr      : clears the sticky overflow flag
//   cnt_val      : registered count
//   tc           : registered terminal-count pulse
//   ovf          : registered sticky overflow flag
module counter_chan
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             cnt_en,
    input  logic             dir,
    input  logic [WIDTH-1:0] limit,
    input  logic             mode,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] cnt_val,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic             tc_q;
    logic             ovf_q;
    logic             term;
    logic             sat;

`ifdef COUNTER_SAT_EN
    assign sat = (cnt_mode_e'(mode) == MODE_SAT);
`else
    logic unused_mode;
    assign unused_mode = mode;
    assign sat         = 1'b0;
`endif

    // Next count and terminal-event detection; clr > load > step > hold.
    always_comb begin
        cnt_nxt = cnt_q;
        term    = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
        end else if (load) begin
            cnt_nxt = load_val;
        end else if (cnt_en) begin
            if (dir == DIR_UP) begin
                // >= so a count above limit (loaded or left by a limit change)
                // terminates on its next up step.
                if (cnt_q >= limit) begin
                    term    = 1'b1;
                    cnt_nxt = sat ? limit : '0;
                end else begin
                    cnt_nxt = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == '0) begin
                    term    = 1'b1;
                    cnt_nxt = sat ? '0 : limit;
                end else begin
                    cnt_nxt = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // State registers; a terminal event beats ovf_clr in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            tc_q  <= term;
            if (term) begin
                ovf_q <= 1'b1;
            end else if (ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign cnt_val = cnt_q;
    assign tc      = tc_q;
    assign ovf     = ovf_q;

endmodule : counter_chan

// File: rtl/counter_multi.sv
// NCH independent up/down counters sharing one limit and mode setting.
// Optional saturate mode is enabled by defining COUNTER_SAT_EN; without it
// every channel wraps and mode is ignored.
// Ports:
//   clk, reset_n      : clock, async active-low reset
//   clr               : synchronous clear of all counts
//   cnt_en[NCH], dir  : per-channel enable and direction (0 up, 1 down)
//   limit             : shared terminal value
//   mode              : 0 wrap, 1 saturate
//   load, load_ch,
//   load_val          : load load_val into channel load_ch (ignored if >= NCH)
//   ovf_clr[NCH]      : per-channel sticky-overflow clear
//   cnt_val           : packed counts, channel k at [k*WIDTH +: WIDTH]
//   tc[NCH]           : registered terminal-count pulses
//   ovf[NCH]          : sticky overflow flags
module counter_multi
    import counter_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    parameter  int unsigned NCH   = 2,
    localparam int unsigned CH_W  = calc_ch_w(NCH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic [NCH-1:0]       cnt_en,
    input  logic [NCH-1:0]       dir,
    input  logic [WIDTH-1:0]     limit,
    input  logic                 mode,
    input  logic                 load,
    input  logic [CH_W-1:0]      load_ch,
    input  logic [WIDTH-1:0]     load_val,
    input  logic [NCH-1:0]       ovf_clr,
    output logic [NCH*WIDTH-1:0] cnt_val,
    output logic [NCH-1:0]       tc,
    output logic [NCH-1:0]       ovf
);

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        // Only indices 0..NCH-1 can match, so out-of-range load_ch loads nothing.
        logic load_k;
        assign load_k = load && (load_ch == CH_W'(k));

        counter_chan #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (clr),
            .load     (load_k),
            .load_val (load_val),
            .cnt_en   (cnt_en[k]),
            .dir      (dir[k]),
            .limit    (limit),
            .mode     (mode),
            .ovf_clr  (ovf_clr[k]),
            .cnt_val  (cnt_val[k*WIDTH +: WIDTH]),
            .tc       (tc[k]),
            .ovf      (ovf[k])
        );
    end

endmodule : counter_multi

// File: tb/tb_counter_multi.sv
// Directed bench for counter_multi (WIDTH=4, NCH=2). Expectations depend on
// whether COUNTER_SAT_EN is defined for the build.
module tb_counter_multi;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned NCH   = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             clr;
    logic [1:0]       cnt_en;
    logic [1:0]       dir;
    logic [3:0]       limit;
    logic             mode;
    logic             load;
    logic [0:0]       load_ch;
    logic [3:0]       load_val;
    logic [1:0]       ovf_clr;
    logic [7:0]       cnt_val;
    logic [1:0]       tc;
    logic [1:0]       ovf;

    int checks = 0;
    int errors = 0;

    counter_multi #(
        .WIDTH (WIDTH),
        .NCH   (NCH)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clr      (clr),
        .cnt_en   (cnt_en),
        .dir      (dir),
        .limit    (limit),
        .mode     (mode),
        .load     (load),
        .load_ch  (load_ch),
        .load_val (load_val),
        .ovf_clr  (ovf_clr),
        .cnt_val  (cnt_val),
        .tc       (tc),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       ld;
        logic       ld_ch;
        logic [3:0] ld_val;
        logic [1:0] en;
        logic [1:0] dir;
        logic [3:0] lim;
        logic       mode;
        logic [1:0] oclr;
        logic [3:0] e0;
        logic [3:0] e1;
        logic [1:0] etc;
        logic [1:0] eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic c, input logic l, input logic lc,
                                input logic [3:0] lv, input logic [1:0] en,
                                input logic [1:0] d, input logic [3:0] lim,
                                input logic m, input logic [1:0] oc,
                                input logic [3:0] e0, input logic [3:0] e1,
                                input logic [1:0] etc, input logic [1:0] eovf);
        vec_t v;
        v.clr = c; v.ld = l; v.ld_ch = lc; v.ld_val = lv; v.en = en; v.dir = d;
        v.lim = lim; v.mode = m; v.oclr = oc; v.e0 = e0; v.e1 = e1;
        v.etc = etc; v.eovf = eovf;
        return v;
    endfunction

    task automatic check(input string nm, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        clr = v.clr; load = v.ld; load_ch = v.ld_ch; load_val = v.ld_val;
        cnt_en = v.en; dir = v.dir; limit = v.lim; mode = v.mode; ovf_clr = v.oclr;
    endtask

    // Drive a vector, clock once, compare all outputs just after the edge.
    task automatic apply(input string nm, input int idx, input vec_t v);
        drive(v);
        @(posedge clk);
        #1;
        check({nm, "_cnt0"}, idx, 32'(cnt_val[3:0]), 32'(v.e0));
        check({nm, "_cnt1"}, idx, 32'(cnt_val[7:4]), 32'(v.e1));
        check({nm, "_tc"},   idx, 32'(tc),           32'(v.etc));
        check({nm, "_ovf"},  idx, 32'(ovf),          32'(v.eovf));
    endtask

    initial begin
        bit sat_en;
        vec_t v;
`ifdef COUNTER_SAT_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        // Table: clr ld ch val en dir lim mode oclr | cnt0 cnt1 tc ovf
        // Up-wrap on ch0 with limit 9; ch1 disabled stays 0.
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(0,0,0,0, 2'b01,2'b00,9,0,2'b00, 4'(i),0,2'b00,2'b00));
        vecs.push_back(mk(0,0,0,0, 2'b01,2'b00,9,0,2'b00, 0,0,2'b01,2'b01));
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b00, 0,0,2'b00,2'b01));
        // Down-wrap on ch1, then clear its overflow.
        vecs.push_back(mk(0,0,0,0, 2'b10,2'b10,9,0,2'b00, 0,9,2'b10,2'b11));
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b10, 0,9,2'b00,2'b01));
        // Overflow race: clear, then clear coinciding with a terminal event.
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b01, 0,9,2'b00,2'b00));
        vecs.push_back(mk(0,0,0,0, 2'b01,2'b01,9,0,2'b01, 9,9,2'b01,2'b01));
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b01, 9,9,2'b00,2'b00));
        // Priority: clr beats load and enable.
        vecs.push_back(mk(1,1,0,5, 2'b11,2'b00,9,0,2'b00, 0,0,2'b00,2'b00));
        // Load 12 (> limit) into ch1 beats its enable; next up step terminates.
        vecs.push_back(mk(0,1,1,12,2'b10,2'b00,9,0,2'b00, 0,12,2'b00,2'b00));
        vecs.push_back(mk(0,0,0,0, 2'b10,2'b00,9,0,2'b00, 0,0,2'b10,2'b10));
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b00, 0,0,2'b00,2'b10));
        // Load into ch0 leaves ch1 free to count.
        vecs.push_back(mk(0,1,0,3, 2'b11,2'b00,9,0,2'b00, 3,1,2'b00,2'b10));
        // Free-running with limit 15: 15 wraps to 0, 14 steps to 15.
        vecs.push_back(mk(0,1,0,15,2'b00,2'b00,15,0,2'b00, 15,1,2'b00,2'b10));
        vecs.push_back(mk(0,0,0,0, 2'b01,2'b00,15,0,2'b00, 0,1,2'b01,2'b11));
        vecs.push_back(mk(0,1,0,14,2'b00,2'b00,15,0,2'b00, 14,1,2'b00,2'b11));
        vecs.push_back(mk(0,0,0,0, 2'b01,2'b00,15,0,2'b00, 15,1,2'b00,2'b11));
        // Limit lowered under a held count: next up step terminates.
        vecs.push_back(mk(0,0,0,0, 2'b01,2'b00,9,0,2'b00, 0,1,2'b01,2'b11));
        vecs.push_back(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b11, 0,1,2'b00,2'b00));

        // Reset and reset state.
        drive(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b00, 0,0,0,0));
        reset_n = 1'b0;
        #1;
        check("reset_cnt", 0, 32'(cnt_val), 32'd0);
        check("reset_tc",  0, 32'(tc),      32'd0);
        check("reset_ovf", 0, 32'(ovf),     32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply("vec", i, vecs[i]);

        // Saturate vs wrap at the boundary: ch0 loaded with 9, up for 3 edges.
        apply("sat_pre", 0, mk(0,1,0,9, 2'b00,2'b00,9,0,2'b00, 9,1,2'b00,2'b00));
        for (int i = 0; i < 3; i++) begin
            v = mk(0,0,0,0, 2'b01,2'b00,9,1,2'b00,
                   sat_en ? 4'd9 : 4'(i), 1,
                   (sat_en || i == 0) ? 2'b01 : 2'b00, 2'b01);
            apply("sat_up", i, v);
        end
        // Count above limit: saturate clamps to limit, wrap goes to 0.
        apply("sat_ld", 0, mk(0,1,0,12,2'b00,2'b00,9,1,2'b00, 12,1,2'b00,2'b01));
        apply("sat_clamp", 0, mk(0,0,0,0, 2'b01,2'b00,9,1,2'b00,
                                 sat_en ? 4'd9 : 4'd0, 1, 2'b01, 2'b01));
        // Down at 0: saturate holds 0, wrap goes to limit.
        apply("sat_ld", 1, mk(0,1,0,0, 2'b00,2'b00,9,1,2'b00, 0,1,2'b00,2'b01));
        apply("sat_down", 0, mk(0,0,0,0, 2'b01,2'b01,9,1,2'b00,
                                sat_en ? 4'd0 : 4'd9, 1, 2'b01, 2'b01));

        // Async reset mid-cycle with ch1 = 1, tc[0] and ovf[0] set.
        drive(mk(0,0,0,0, 2'b00,2'b00,9,0,2'b00, 0,0,0,0));
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_cnt", 0, 32'(cnt_val), 32'd0);
        check("async_rst_tc",  0, 32'(tc),      32'd0);
        check("async_rst_ovf", 0, 32'(ovf),     32'd0);
        @(posedge clk);
        #3 reset_n = 1'b1;
        // With NCH=2 every load_ch code names a real channel, so only the
        // in-range decode is exercised here.
        apply("post_rst", 0, mk(0,0,0,0, 2'b11,2'b00,9,0,2'b00, 1,1,2'b00,2'b00));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_counter_multi
